// File: rtl/lock_pkg.sv
// Shared types and key constants for the keypad code lock.
package lock_pkg;

    typedef enum logic [2:0] {
        StLocked,
        StEntry,
        StCheck,
        StUnlocked,
        StProgram,
        StLockout
    } lock_state_t;

    typedef struct packed {
        logic locked;
        logic unlocked;
        logic alarm;
    } lock_status_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_PROG  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_LOCK  = 4'hD;

    function automatic lock_status_t st_status(lock_state_t s);
        lock_status_t r;
        r.locked   = (s == StLocked) || (s == StEntry) || (s == StCheck) || (s == StLockout);
        r.unlocked = (s == StUnlocked) || (s == StProgram);
        r.alarm    = (s == StLockout);
        return r;
    endfunction

endpackage

// File: rtl/code_entry_buffer.sv
// Digit entry shift register with saturating count and per-position blank flags.
module code_entry_buffer #(
    parameter int unsigned CODE_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shift,
    input  logic                          clear,
    input  logic [3:0]                    digit,
    output logic [4*CODE_LEN-1:0]         digits,
    output logic [CODE_LEN-1:0]           blank,
    output logic [$clog2(CODE_LEN+1)-1:0] count
);

    localparam int unsigned DW = 4 * CODE_LEN;
    localparam int unsigned CW = $clog2(CODE_LEN + 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            digits <= '0;
            blank  <= '1;
            count  <= '0;
        end else if (shift) begin
            // Oldest digit falls off the top once the buffer is full.
            digits <= (digits << 4) | DW'(digit);
            blank  <= blank << 1;
            if (count != CW'(CODE_LEN)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_code_lock.sv
// Code-entry lock core: state machine, timers, stored code and display mux phase.
module keypad_code_lock
    import lock_pkg::*;
#(
    parameter int unsigned          CODE_LEN      = 4,
    parameter int unsigned          MAX_TRIES     = 3,
    parameter int unsigned          LOCKOUT_TICKS = 10,
    parameter int unsigned          RELOCK_TICKS  = 5,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
    parameter int unsigned          MUX_PHASES    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic [3:0]                     key_code,
    input  logic                           sec_tick,
    input  logic                           mux_tick,
    output logic [4*CODE_LEN-1:0]          disp_digits,
    output logic [CODE_LEN-1:0]            disp_blank,
    output logic [$clog2(MUX_PHASES)-1:0]  mux_sel,
    output logic                           locked,
    output logic                           unlocked,
    output logic                           alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

    localparam int unsigned TMAX = (LOCKOUT_TICKS > RELOCK_TICKS) ? LOCKOUT_TICKS : RELOCK_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned CW   = $clog2(CODE_LEN + 1);
    localparam int unsigned MW   = $clog2(MUX_PHASES);

    lock_state_t             state;
    lock_status_t            status;
    logic [4*CODE_LEN-1:0]   stored;
    logic [TW-1:0]           timer;
    logic [CW-1:0]           count;
    logic                    is_digit, shift, clear, full, match;
    logic                    k_enter, k_prog, k_clear, k_lock;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign k_enter  = key_valid && (key_code == KEY_ENTER);
    assign k_prog   = key_valid && (key_code == KEY_PROG);
    assign k_clear  = key_valid && (key_code == KEY_CLEAR);
    assign k_lock   = key_valid && (key_code == KEY_LOCK);

    assign full  = (count == CW'(CODE_LEN));
    assign match = full && (disp_digits == stored);
    assign shift = is_digit && (state == StLocked || state == StEntry || state == StProgram);
    // Buffer is emptied on CLEAR, on every exit from CHECK, and on entering/leaving PROGRAM.
    assign clear = (k_clear && state != StLockout) || (state == StCheck) ||
                   (k_enter && state == StProgram) || (k_prog && state == StUnlocked);

    code_entry_buffer #(
        .CODE_LEN (CODE_LEN)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .shift  (shift),
        .clear  (clear),
        .digit  (key_code),
        .digits (disp_digits),
        .blank  (disp_blank),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StLocked;
            status   <= st_status(StLocked);
            stored   <= DEFAULT_CODE;
            timer    <= '0;
            fail_cnt <= '0;
        end else begin
            case (state)
                StLocked: begin
                    if (shift) begin
                        state  <= StEntry;
                        status <= st_status(StEntry);
                    end
                end
                StEntry: begin
                    if (k_enter) begin
                        state  <= StCheck;
                        status <= st_status(StCheck);
                    end
                end
                StCheck: begin
                    if (match) begin
                        state    <= StUnlocked;
                        status   <= st_status(StUnlocked);
                        fail_cnt <= '0;
                        timer    <= TW'(RELOCK_TICKS);
                    end else if (32'(fail_cnt) + 32'd1 >= MAX_TRIES) begin
                        state    <= StLockout;
                        status   <= st_status(StLockout);
                        fail_cnt <= fail_cnt + 1'b1;
                        timer    <= TW'(LOCKOUT_TICKS);
                    end else begin
                        state    <= StLocked;
                        status   <= st_status(StLocked);
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                end
                StLockout: begin
                    if (sec_tick) begin
                        if (timer <= TW'(1)) begin
                            state    <= StLocked;
                            status   <= st_status(StLocked);
                            fail_cnt <= '0;
                            timer    <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                StUnlocked: begin
                    // An acted-on key takes precedence over a same-cycle tick.
                    if (k_lock) begin
                        state  <= StLocked;
                        status <= st_status(StLocked);
                        timer  <= '0;
                    end else if (k_prog) begin
                        state  <= StProgram;
                        status <= st_status(StProgram);
                    end else if (sec_tick) begin
                        if (timer <= TW'(1)) begin
                            state  <= StLocked;
                            status <= st_status(StLocked);
                            timer  <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                StProgram: begin
                    if (k_enter) begin
                        if (full) begin
                            stored <= disp_digits;
                            state  <= StLocked;
                            status <= st_status(StLocked);
                            timer  <= '0;
                        end else begin
                            state  <= StUnlocked;
                            status <= st_status(StUnlocked);
                            timer  <= TW'(RELOCK_TICKS);
                        end
                    end
                end
                default: begin
                    state  <= StLocked;
                    status <= st_status(StLocked);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_sel <= '0;
        end else if (mux_tick) begin
            mux_sel <= (mux_sel == MW'(MUX_PHASES - 1)) ? '0 : mux_sel + 1'b1;
        end
    end

    assign locked   = status.locked;
    assign unlocked = status.unlocked;
    assign alarm    = status.alarm;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed self-checking bench for keypad_code_lock with default parameters.
module tb_keypad_code_lock;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        sec_tick = 1'b0;
    logic        mux_tick = 1'b0;
    logic [15:0] disp_digits;
    logic [3:0]  disp_blank;
    logic [0:0]  mux_sel;
    logic        locked, unlocked, alarm;
    logic [1:0]  fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_code_lock dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .sec_tick    (sec_tick),
        .mux_tick    (mux_tick),
        .disp_digits (disp_digits),
        .disp_blank  (disp_blank),
        .mux_sel     (mux_sel),
        .locked      (locked),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic press(input logic [3:0] k, input logic with_tick);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        sec_tick  = with_tick;
        @(negedge clk);
        key_valid = 1'b0;
        sec_tick  = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        press(k, 1'b0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sec_tick = 1'b1;
            @(negedge clk) sec_tick = 1'b0;
        end
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) key(code[4*i +: 4]);
        key(4'hA);
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        check_eq("rst_locked", locked, 1);
        check_eq("rst_unlocked", unlocked, 0);
        check_eq("rst_alarm", alarm, 0);
        check_eq("rst_fail", fail_cnt, 0);
        check_eq("rst_blank", disp_blank, 4'b1111);
        check_eq("rst_digits", disp_digits, 0);
        check_eq("rst_mux", mux_sel, 0);

        // 1: correct code, result two cycles after ENTER
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        check_eq("t1_digits", disp_digits, 16'h1234);
        check_eq("t1_blank_full", disp_blank, 4'b0000);
        key(4'hA);
        check_eq("t1_check_cycle", unlocked, 0);
        @(negedge clk);
        check_eq("t1_unlocked", unlocked, 1);
        check_eq("t1_locked", locked, 0);
        check_eq("t1_fail", fail_cnt, 0);
        check_eq("t1_blank", disp_blank, 4'b1111);
        key(4'hD);
        check_eq("t1_lock_key", locked, 1);

        // 2: three short entries -> lockout
        for (int t = 1; t <= 3; t++) begin
            key(4'h1); key(4'h2);
            if (t == 1) begin
                check_eq("t2_digits", disp_digits, 16'h0012);
                check_eq("t2_blank", disp_blank, 4'b1100);
            end
            key(4'hA);
            @(negedge clk);
            check_eq($sformatf("t2_fail%0d", t), fail_cnt, t);
        end
        check_eq("t2_alarm", alarm, 1);
        check_eq("t2_lo_locked", locked, 1);
        key(4'h5);
        check_eq("t2_digit_ignored", disp_blank, 4'b1111);
        tick(9);
        check_eq("t2_alarm_9", alarm, 1);
        tick(1);
        check_eq("t2_alarm_10", alarm, 0);
        check_eq("t2_locked_10", locked, 1);
        check_eq("t2_fail_10", fail_cnt, 0);

        // 3: overflow drops oldest digit; auto-relock after 5 ticks
        key(4'h9);
        enter_code(16'h1234);
        check_eq("t3_unlocked", unlocked, 1);
        tick(4);
        check_eq("t3_still_unl", unlocked, 1);
        tick(1);
        check_eq("t3_relocked", locked, 1);

        // 4: program a new code
        enter_code(16'h1234);
        key(4'hB);
        check_eq("t4_program", unlocked, 1);
        key(4'h5); key(4'h6); key(4'h7); key(4'h8);
        check_eq("t4_prog_digits", disp_digits, 16'h5678);
        key(4'hA);
        check_eq("t4_prog_locked", locked, 1);
        enter_code(16'h1234);
        check_eq("t4_old_fails", fail_cnt, 1);
        check_eq("t4_old_locked", locked, 1);
        enter_code(16'h5678);
        check_eq("t4_new_unlocks", unlocked, 1);
        check_eq("t4_fail_clr", fail_cnt, 0);
        do_reset();
        enter_code(16'h1234);
        check_eq("t4_rst_default", unlocked, 1);

        // 5: key beats same-cycle relock expiry
        tick(4);
        press(4'hD, 1'b1);
        check_eq("t5_lock_tick", locked, 1);
        enter_code(16'h1234);
        tick(4);
        press(4'hB, 1'b1);
        check_eq("t5_prog_tick", unlocked, 1);
        tick(6);
        check_eq("t5_prog_no_tick", unlocked, 1);
        key(4'h7);
        check_eq("t5_prog_shift", disp_blank, 4'b1110);
        key(4'hA);
        check_eq("t5_short_unl", unlocked, 1);
        check_eq("t5_short_blank", disp_blank, 4'b1111);
        tick(4);
        check_eq("t5_reload", unlocked, 1);
        tick(1);
        check_eq("t5_relock", locked, 1);

        // 6: CLEAR and mux phase
        key(4'h3);
        check_eq("t6_blank_one", disp_blank, 4'b1110);
        key(4'hC);
        check_eq("t6_clear", disp_blank, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) mux_tick = 1'b1;
            @(negedge clk) mux_tick = 1'b0;
            check_eq($sformatf("t6_mux%0d", i), mux_sel, (i % 2 == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
